// File: rtl/fp_mul_seq.sv
// Sequential floating-point multiplier: shift-add significand product, normalise, range check.
// Define FP_MUL_RNE_EN for round-to-nearest-even; otherwise the result is truncated.
module fp_mul_seq #(
    parameter  int EXP_W = 8,
    parameter  int MAN_W = 23,
    localparam int W     = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         overflow,
    output logic         underflow,
    output logic         invalid
);

    localparam int SIG_W  = MAN_W + 1;
    localparam int PROD_W = 2 * SIG_W;
    localparam int XW     = EXP_W + 2;
    localparam int CNT_W  = $clog2(SIG_W);

    localparam logic signed [XW-1:0] BIAS    = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);
    localparam logic [W-1:0]         QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_NORM,
        S_DONE
    } state_t;

    state_t state, state_n;

    logic [CNT_W-1:0]     cnt;
    logic [PROD_W-1:0]    mcand;
    logic [SIG_W-1:0]     mplier;
    logic [PROD_W-1:0]    prod;
    logic signed [XW-1:0] exp_q;
    logic                 sign_q;

    // ---------------- operand decode (used only at capture) ----------------
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] frac_a, frac_b;
    logic             sign_ab;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
    logic signed [XW-1:0] exp_raw;
    logic [W-1:0]     special_res;
    logic             special_inv;

    assign exp_a   = a[W-2:MAN_W];
    assign exp_b   = b[W-2:MAN_W];
    assign frac_a  = a[MAN_W-1:0];
    assign frac_b  = b[MAN_W-1:0];
    assign sign_ab = a[W-1] ^ b[W-1];

    // exp == 0 counts as zero, so denormal inputs are flushed.
    assign a_zero  = (exp_a == '0);
    assign b_zero  = (exp_b == '0);
    assign a_inf   = (&exp_a) && (frac_a == '0);
    assign b_inf   = (&exp_b) && (frac_b == '0);
    assign a_nan   = (&exp_a) && (frac_a != '0);
    assign b_nan   = (&exp_b) && (frac_b != '0);
    assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

    assign exp_raw = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - BIAS;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        special_res = {sign_ab, {(W-1){1'b0}}};
        special_inv = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            special_res = QNAN;
            special_inv = 1'b1;
        end else if (a_inf || b_inf) begin
            special_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end
    end

    // ---------------- normalise, round and range check ----------------
    logic [MAN_W-1:0]     frac_t, frac_f;
    logic signed [XW-1:0] exp_n, exp_f;
    logic [W-1:0]         norm_res;
    logic                 norm_ovf, norm_unf;

`ifdef FP_MUL_RNE_EN
    logic             guard, sticky;
    logic [MAN_W:0]   frac_r;
`else
    logic             unused_dropped;
    assign unused_dropped = |prod[MAN_W-1:0];
`endif

    always_comb begin
        if (prod[PROD_W-1]) begin
            frac_t = prod[PROD_W-2 -: MAN_W];
            exp_n  = exp_q + XW'(1);
        end else begin
            frac_t = prod[PROD_W-3 -: MAN_W];
            exp_n  = exp_q;
        end

`ifdef FP_MUL_RNE_EN
        guard  = prod[PROD_W-1] ? prod[MAN_W] : prod[MAN_W-1];
        sticky = prod[PROD_W-1] ? |prod[MAN_W-1:0] : |prod[MAN_W-2:0];
        frac_r = {1'b0, frac_t} + (MAN_W+1)'(guard & (sticky | frac_t[0]));
        // A carry out means the significand rolled over to 10.0, so fraction is 0 and exponent bumps.
        frac_f = frac_r[MAN_W-1:0];
        exp_f  = frac_r[MAN_W] ? exp_n + XW'(1) : exp_n;
`else
        frac_f = frac_t;
        exp_f  = exp_n;
`endif

        norm_ovf = 1'b0;
        norm_unf = 1'b0;
        norm_res = {sign_q, exp_f[EXP_W-1:0], frac_f};
        if (exp_f >= EXP_MAX) begin
            norm_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            norm_ovf = 1'b1;
        end else if (exp_f[XW-1] || exp_f == '0) begin
            norm_res = {sign_q, {(W-1){1'b0}}};
            norm_unf = 1'b1;
        end
    end

    // ---------------- control FSM ----------------
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (start) state_n = special ? S_DONE : S_MUL;
            S_MUL:  if (cnt == CNT_W'(MAN_W)) state_n = S_NORM;
            S_NORM: state_n = S_DONE;
            S_DONE: state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

    // ---------------- datapath ----------------
    // NOTE: the datapath registers are reset too, so an aborted operation leaves no stale result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            exp_q     <= '0;
            sign_q    <= 1'b0;
            result    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            invalid   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cnt       <= '0;
                        mcand     <= {{SIG_W{1'b0}}, 1'b1, frac_a};
                        mplier    <= {1'b1, frac_b};
                        prod      <= '0;
                        exp_q     <= exp_raw;
                        sign_q    <= sign_ab;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        invalid   <= 1'b0;
                        if (special) begin
                            result  <= special_res;
                            invalid <= special_inv;
                        end
                    end
                end
                S_MUL: begin
                    if (mplier[0]) prod <= prod + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    if (cnt != CNT_W'(MAN_W)) cnt <= cnt + CNT_W'(1);
                end
                S_NORM: begin
                    result    <= norm_res;
                    overflow  <= norm_ovf;
                    underflow <= norm_unf;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed scoreboard bench for fp_mul_seq (single precision defaults).
module tb_fp_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;
    logic        overflow, underflow, invalid;

    fp_mul_seq dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .overflow  (overflow),
        .underflow (underflow),
        .invalid   (invalid)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flags;   // {overflow, underflow, invalid}
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    localparam int NORM_LAT = 26;
    localparam int SPEC_LAT = 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, ":busy"},   32'(busy), 32'd0);
        check({tag, ":done"},   32'(done), 32'd0);
        check({tag, ":result"}, result, 32'd0);
        check({tag, ":flags"},  32'({overflow, underflow, invalid}), 32'd0);
    endtask

    // Start one operation, optionally pulse a second start at cycle t+dup_at, then
    // compare latency, busy, result and flags against the scoreboard entry.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic [31:0] e_res, input logic [2:0] e_flags,
                          input int e_lat, input int dup_at);
        exp_t got;
        int   n;
        logic busy_ok;
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        sb.push_back('{res: e_res, flags: e_flags});
        @(negedge clk);
        start   = 1'b0;
        a       = $urandom;
        b       = $urandom;
        n       = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && n <= 60) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            start = (n == dup_at);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({tag, ":latency"}, 32'(n), 32'(e_lat));
        check({tag, ":busy"}, 32'({busy_ok, busy}), 32'd3);
        got = '0;
        if (sb.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL %s:scoreboard observed empty expected entry", tag);
        end else begin
            got = sb.pop_front();
        end
        check({tag, ":result"}, result, got.res);
        check({tag, ":flags"}, 32'({overflow, underflow, invalid}), 32'(got.flags));
        @(negedge clk);
        check({tag, ":pulse"}, 32'(done), 32'd0);
        check({tag, ":hold"}, result, got.res);
        check({tag, ":hold_flags"}, 32'({overflow, underflow, invalid}), 32'(got.flags));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no end of test expected finish before 1ms");
        $fatal(1);
    end

    initial begin
        logic seen_done;
        logic [31:0] tie_exp;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        run_op("mul_2x3",     32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, NORM_LAT, 0);
        run_op("mul_1p5sq",   32'h3FC00000, 32'h3FC00000, 32'h40100000, 3'b000, NORM_LAT, 0);
        run_op("mul_neg",     32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000, NORM_LAT, 0);
        run_op("mul_negneg",  32'hBFC00000, 32'hBFC00000, 32'h40100000, 3'b000, NORM_LAT, 0);
        run_op("zero_x3",     32'h00000000, 32'h40400000, 32'h00000000, 3'b000, SPEC_LAT, 0);
        run_op("negzero_x3",  32'h80000000, 32'h40400000, 32'h80000000, 3'b000, SPEC_LAT, 0);
        run_op("inf_x0",      32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b001, SPEC_LAT, 0);
        run_op("inf_xneg3",   32'h7F800000, 32'hC0400000, 32'hFF800000, 3'b000, SPEC_LAT, 0);
        run_op("nan_x1",      32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b001, SPEC_LAT, 0);
        run_op("denorm_x3",   32'h00000001, 32'h40400000, 32'h00000000, 3'b000, SPEC_LAT, 0);
        run_op("ovf",         32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100, NORM_LAT, 0);
        run_op("ovf_neg",     32'hFF000000, 32'h7F000000, 32'hFF800000, 3'b100, NORM_LAT, 0);
        run_op("unf",         32'h00800000, 32'h00800000, 32'h00000000, 3'b010, NORM_LAT, 0);
`ifdef FP_MUL_RNE_EN
        tie_exp = 32'h3FC00002;
`else
        tie_exp = 32'h3FC00001;
`endif
        run_op("tie",         32'h3F800001, 32'h3FC00000, tie_exp,      3'b000, NORM_LAT, 0);
        run_op("dup_start",   32'h40000000, 32'h40400000, 32'h40C00000, 3'b000, NORM_LAT, 5);

        // Abort an operation at t+10; the previous non-zero result must clear at once.
        @(negedge clk);
        a     = 32'h3FC00000;
        b     = 32'h3FC00000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        check_zero("abort");
        @(negedge clk);
        rst       = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) seen_done = 1'b1;
        end
        check("abort:no_done", 32'(seen_done), 32'd0);
        check("abort:idle", 32'(busy), 32'd0);

        run_op("after_rst",   32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000, NORM_LAT, 0);

        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
